// File: rtl/fighter_pkg.sv
// fighter_pkg: action state encodings and default frame timing shared by the per-player fighter logic.
// Contents: state_t (drives the action output directly), ACTION_KO, and default frame counts and counter width.
package fighter_pkg;
  localparam int STARTUP_FRAMES_DEF  = 3;
  localparam int ACTIVE_FRAMES_DEF   = 4;
  localparam int RECOVERY_FRAMES_DEF = 6;
  localparam int HITSTUN_FRAMES_DEF  = 12;
  localparam int CNT_WIDTH_DEF       = 5;
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WALK       = 3'd1,
    JUMP_REQ   = 3'd2,
    JUMP_AIR   = 3'd3,
    ATK_START  = 3'd4,
    ATK_ACTIVE = 3'd5,
    ATK_RECOV  = 3'd6,
    HITSTUN    = 3'd7
  } state_t;
  localparam logic [2:0] ACTION_KO = 3'd7;
endpackage

// File: rtl/frame_timer.sv
// frame_timer: loadable frame down-counter that moves only on SCEN frames.
// Ports: clk, reset (async, active-low), scen (frame tick), load/load_val (reload on a tick),
//        done (count has reached zero).
module frame_timer #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         scen,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);
  logic [W-1:0] count;
  assign done = count == '0;
  always_ff @(posedge clk or negedge reset)
    if (!reset) count <= '0;
    else if (scen) count <= load ? load_val : (done ? count : count - W'(1));
endmodule

// File: rtl/player_action_ctrl.sv
// player_action_ctrl: frame-paced per-player action sequencer that gates player_move and publishes the hitbox window.
// Ports: clk, reset (async, active-low), SCEN (frame tick), btn_left/right/jump/attack (level buttons),
//        hit_taken (pulse, any cycle), ko (level), jump_active (from player_move);
//        move_enable/move_left/move_right/jump (to player_move), attack_active, action[2:0], busy.
module player_action_ctrl
  import fighter_pkg::*;
#(
  parameter int STARTUP_FRAMES  = STARTUP_FRAMES_DEF,
  parameter int ACTIVE_FRAMES   = ACTIVE_FRAMES_DEF,
  parameter int RECOVERY_FRAMES = RECOVERY_FRAMES_DEF,
  parameter int HITSTUN_FRAMES  = HITSTUN_FRAMES_DEF,
  parameter int CNT_WIDTH       = CNT_WIDTH_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       SCEN,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_jump,
  input  logic       btn_attack,
  input  logic       hit_taken,
  input  logic       ko,
  input  logic       jump_active,
  output logic       move_enable,
  output logic       move_left,
  output logic       move_right,
  output logic       jump,
  output logic       attack_active,
  output logic [2:0] action,
  output logic       busy
);
  localparam logic [CNT_WIDTH-1:0] SU = CNT_WIDTH'(STARTUP_FRAMES - 1);
  localparam logic [CNT_WIDTH-1:0] AF = CNT_WIDTH'(ACTIVE_FRAMES - 1);
  localparam logic [CNT_WIDTH-1:0] RF = CNT_WIDTH'(RECOVERY_FRAMES - 1);
  localparam logic [CNT_WIDTH-1:0] HF = CNT_WIDTH'(HITSTUN_FRAMES - 1);
  state_t                 state, nxt;
  logic                   ko_latched, ko_n, hit_pend, hit, done, load, one_dir, dir_state;
  logic [CNT_WIDTH-1:0]   load_val;
  // A hit arriving on the tick itself is consumed by that tick's decision.
  assign hit     = hit_pend | hit_taken;
  assign one_dir = btn_left ^ btn_right;
  always_comb begin
    nxt  = state;
    ko_n = ko_latched | ko;
    if (!ko_n)
      case (state)
        IDLE, WALK: nxt = hit ? HITSTUN : btn_attack ? ATK_START : btn_jump ? JUMP_REQ :
                          one_dir ? WALK : IDLE;
        JUMP_REQ:   nxt = JUMP_AIR;
        // Airborne hits stay pending until landing.
        JUMP_AIR:   nxt = jump_active ? JUMP_AIR : hit ? HITSTUN : IDLE;
        ATK_START:  nxt = hit ? HITSTUN : done ? ATK_ACTIVE : ATK_START;
        ATK_ACTIVE: nxt = hit ? HITSTUN : done ? ATK_RECOV : ATK_ACTIVE;
        ATK_RECOV:  nxt = hit ? HITSTUN : done ? IDLE : ATK_RECOV;
        default:    nxt = hit ? HITSTUN : done ? IDLE : HITSTUN;
      endcase
  end
  // Every state change reloads the timer; a fresh hit during stun also restarts it.
  assign load      = !ko_n && (nxt != state || (state == HITSTUN && hit));
  assign load_val  = nxt == ATK_START ? SU : nxt == ATK_ACTIVE ? AF : nxt == ATK_RECOV ? RF :
                     nxt == HITSTUN ? HF : '0;
  assign dir_state = !ko_n && (nxt == WALK || nxt == JUMP_REQ);
  frame_timer #(.W(CNT_WIDTH)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .scen     (SCEN),
    .load     (load),
    .load_val (load_val),
    .done     (done)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) hit_pend <= 1'b0;
    else hit_pend <= (SCEN && !ko_n && nxt == HITSTUN) ? 1'b0 : hit;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state         <= IDLE;
      ko_latched    <= 1'b0;
      move_enable   <= 1'b0;
      move_left     <= 1'b0;
      move_right    <= 1'b0;
      jump          <= 1'b0;
      attack_active <= 1'b0;
      action        <= 3'd0;
      busy          <= 1'b0;
    end else if (SCEN) begin
      state         <= nxt;
      ko_latched    <= ko_n;
      move_enable   <= !ko_n && nxt inside {IDLE, WALK, JUMP_REQ, JUMP_AIR};
      move_left     <= dir_state && btn_left && !btn_right;
      move_right    <= dir_state && btn_right && !btn_left;
      jump          <= !ko_n && nxt == JUMP_REQ;
      attack_active <= !ko_n && nxt == ATK_ACTIVE;
      action        <= ko_n ? ACTION_KO : nxt;
      busy          <= ko_n || !(nxt inside {IDLE, WALK});
    end
endmodule

// File: tb/tb_player_action_ctrl.sv
// tb_player_action_ctrl: randomized and directed checks of player_action_ctrl against a frame-level reference model.
module tb_player_action_ctrl;
  logic clk = 0, reset = 0, scen = 0, bl = 0, br = 0, bj = 0, ba = 0, hit_in = 0, ko = 0, jact = 0;
  logic move_enable, move_left, move_right, jump, attack_active, busy;
  logic [2:0] action;
  logic [8:0] got;
  int checks = 0, errors = 0;
  int m_mode, m_age, air;
  bit m_pend, m_ko, m_dl, m_dr, m_fresh;

  always #5 clk = ~clk;
  assign got = {action, busy, move_enable, move_left, move_right, jump, attack_active};

  player_action_ctrl dut (
    .clk(clk), .reset(reset), .SCEN(scen), .btn_left(bl), .btn_right(br), .btn_jump(bj),
    .btn_attack(ba), .hit_taken(hit_in), .ko(ko), .jump_active(jact), .move_enable(move_enable),
    .move_left(move_left), .move_right(move_right), .jump(jump), .attack_active(attack_active),
    .action(action), .busy(busy)
  );

  function automatic int dur(input int m);
    return m == 4 ? 3 : m == 5 ? 4 : m == 6 ? 6 : m == 7 ? 12 : 1;
  endfunction

  function automatic logic [8:0] m_out();
    if (m_fresh) return 9'd0;
    if (m_ko) return {3'd7, 1'b1, 5'b0};
    case (m_mode)
      0: return {3'd0, 1'b0, 1'b1, 4'b0};
      1: return {3'd1, 1'b0, 1'b1, m_dl, m_dr, 2'b0};
      2: return {3'd2, 1'b1, 1'b1, m_dl, m_dr, 1'b1, 1'b0};
      3: return {3'd3, 1'b1, 1'b1, 4'b0};
      5: return {3'd5, 1'b1, 4'b0, 1'b1};
      default: return {3'(m_mode), 1'b1, 5'b0};
    endcase
  endfunction

  task automatic enter(input int s);
    m_mode = s;
    m_age = 1;
  endtask

  task automatic model_reset();
    m_mode = 0; m_age = 0; m_pend = 0; m_ko = 0; m_dl = 0; m_dr = 0; m_fresh = 1; air = 0; jact = 0;
  endtask

  task automatic model_scen(input bit l, r, j, a, hn, k, ja);
    bit h, used;
    h = m_pend | hn;
    used = 0;
    m_fresh = 0;
    if (m_ko) ;
    else if (k) m_ko = 1;
    else case (m_mode)
      0, 1: if (h) begin enter(7); used = 1; end
            else if (a) enter(4);
            else if (j) begin enter(2); m_dl = l & !r; m_dr = r & !l; end
            else if (l ^ r) begin enter(1); m_dl = l; m_dr = r; end
            else enter(0);
      2: enter(3);
      3: if (!ja) begin if (h) begin enter(7); used = 1; end else enter(0); end
      default: if (h) begin enter(7); used = 1; end
               else if (m_age == dur(m_mode)) enter(m_mode == 4 ? 5 : m_mode == 5 ? 6 : 0);
               else m_age++;
    endcase
    m_pend = used ? 0 : h;
  endtask

  // One frame: buttons set, optional mid-frame hit pulse, then the SCEN tick; outputs sampled on the following negedge.
  task automatic step(input bit l, r, j, a, hm, hn, k);
    bit jump_seen, ja;
    @(negedge clk); {bl, br, bj, ba} = {l, r, j, a}; ko = k; hit_in = hm; scen = 0;
    @(negedge clk); hit_in = 0;
    if (hm) m_pend = 1;
    @(negedge clk); scen = 1; hit_in = hn;
    jump_seen = jump; ja = jact;
    model_scen(l, r, j, a, hn, k, ja);
    @(negedge clk); scen = 0; hit_in = 0;
    if (jump_seen) air = 16; else if (air > 0) air--;
    jact = air > 0;
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 0; {bl, br, bj, ba, hit_in, ko, scen} = '0;
    model_reset();
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk); reset = 1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (got !== 9'd0) begin errors++; $display("FAIL reset_outputs got %b want %b", got, 9'd0); end
    release_reset();
    br = 1;
    repeat (4) @(negedge clk);
    checks++; if (got !== 9'd0) begin errors++; $display("FAIL no_scen_hold got %b want %b", got, 9'd0); end
    br = 0;
  endtask

  task automatic test_walk();
    int rc = 0;
    for (int i = 0; i < 7; i++) begin
      step(0, i < 5, 0, 0, 0, 0, 0);
      rc += move_right;
      checks++; if (got !== m_out()) begin errors++; $display("FAIL walk f%0d got %b want %b", i, got, m_out()); end
    end
    checks++; if (rc != 5) begin errors++; $display("FAIL walk_right_frames got %0d want 5", rc); end
  endtask

  task automatic test_attack();
    int ac = 0, idle_at = 0;
    for (int i = 1; i <= 16; i++) begin
      step(0, 0, 0, i == 1, 0, 0, 0);
      ac += attack_active;
      if (idle_at == 0 && i > 1 && action == 3'd0) idle_at = i;
      checks++; if (got !== m_out()) begin errors++; $display("FAIL attack f%0d got %b want %b", i, got, m_out()); end
    end
    checks++; if (ac != 4) begin errors++; $display("FAIL attack_active_frames got %0d want 4", ac); end
    checks++; if (idle_at != 14) begin errors++; $display("FAIL attack_idle_frame got %0d want 14", idle_at); end
  endtask

  task automatic test_jump();
    int jc = 0;
    for (int i = 1; i <= 22; i++) begin
      step(i == 1, 0, i == 1, i >= 5 && i <= 8, 0, 0, 0);
      jc += jump;
      checks++; if (got !== m_out()) begin errors++; $display("FAIL jump f%0d got %b want %b", i, got, m_out()); end
    end
    checks++; if (jc != 1) begin errors++; $display("FAIL jump_pulse_frames got %0d want 1", jc); end
  endtask

  task automatic test_hit_attack();
    for (int i = 1; i <= 30; i++) begin
      step(0, 0, 0, i == 1, i == 6 || i == 16, 0, 0);
      checks++; if (got !== m_out()) begin errors++; $display("FAIL hit_atk f%0d got %b want %b", i, got, m_out()); end
      if (i == 6) begin
        checks++; if ({action, attack_active} !== 4'b1110) begin errors++; $display("FAIL hit_abort got %b want 1110", {action, attack_active}); end
      end
      if (i == 27) begin
        checks++; if (action !== 3'd7) begin errors++; $display("FAIL restun_last got %0d want 7", action); end
      end
      if (i == 28) begin
        checks++; if (action !== 3'd0) begin errors++; $display("FAIL restun_exit got %0d want 0", action); end
      end
    end
  endtask

  task automatic test_hit_air();
    for (int i = 1; i <= 34; i++) begin
      step(0, 0, i == 1, 0, i == 5, 0, 0);
      checks++; if (got !== m_out()) begin errors++; $display("FAIL hit_air f%0d got %b want %b", i, got, m_out()); end
    end
  endtask

  task automatic test_ko();
    for (int i = 1; i <= 6; i++) begin
      step(i > 3, 1, i > 3, i > 3, i == 5, i == 6, i == 3);
      checks++; if (got !== m_out()) begin errors++; $display("FAIL ko f%0d got %b want %b", i, got, m_out()); end
    end
    do_reset();
    checks++; if (got !== 9'd0) begin errors++; $display("FAIL ko_reset got %b want %b", got, 9'd0); end
    release_reset();
    step(0, 0, 0, 0, 0, 0, 0);
    checks++; if (got !== m_out()) begin errors++; $display("FAIL ko_after got %b want %b", got, m_out()); end
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 32; i++) begin
      step(0, 0, 0, 1, 0, i == 20, 0);
      checks++; if (got !== m_out()) begin errors++; $display("FAIL b2b f%0d got %b want %b", i, got, m_out()); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 149) == 0);
      checks++; if (got !== m_out()) begin errors++; $display("FAIL random f%0d got %b want %b", i, got, m_out()); end
      if (m_ko && $urandom_range(0, 3) == 0) begin
        do_reset();
        checks++; if (got !== 9'd0) begin errors++; $display("FAIL random_reset got %b want %b", got, 9'd0); end
        release_reset();
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_walk();
    test_attack();
    test_jump();
    test_hit_attack();
    test_hit_air();
    test_ko();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/player_action_ctrl.md
# player_action_ctrl

Per-player action sequencer sitting between the debounced button inputs and `player_move`. Runs a frame-paced state machine (idle, walk, jump, three-phase attack, hitstun, KO) and decides each frame what `player_move` may do. Drives its `move_enable`, `move_left`, `move_right` and `jump` inputs, and publishes the attack hitbox window and current action to collision and sprite logic. One instance per player.

## Interface
Parameters:
- `STARTUP_FRAMES`, 3: attack wind-up frames (≥1)
- `ACTIVE_FRAMES`, 4: hitbox-valid frames (≥1)
- `RECOVERY_FRAMES`, 6: post-attack lockout frames (≥1)
- `HITSTUN_FRAMES`, 12: stun frames after a hit (≥1)
- `CNT_WIDTH`, 5: frame counter width; must hold max(frame params)−1

Ports:
- `clk` in 1: system clock
- `reset` in 1: asynchronous, active-low reset (asserted at 0)
- `SCEN` in 1: one-cycle frame tick; all state advances only on cycles with `SCEN`=1
- `btn_left`, `btn_right`, `btn_jump`, `btn_attack` in 1 each: level button inputs
- `hit_taken` in 1: one-cycle pulse from collision logic, any cycle
- `ko` in 1: level, health reached zero
- `jump_active` in 1: from `player_move`
- `move_enable`, `move_left`, `move_right`, `jump` out 1 each: to `player_move`
- `attack_active` out 1: hitbox valid
- `action` out 3: current state encoding
- `busy` out 1: state is not IDLE or WALK

## Operation
- States/encodings: IDLE=0, WALK=1, JUMP_REQ=2, JUMP_AIR=3, ATK_START=4, ATK_ACTIVE=5, ATK_RECOV=6, HITSTUN=7. KO shares `action`=7 with a separate sticky `ko_latched` flag.
- Timed states load counter = N−1 on entry, decrement each SCEN, exit on the SCEN where the counter is 0. Each timed state lasts exactly N frames.
- `hit_taken` is latched into `hit_pend` on any cycle. `hit_pend` is cleared on the SCEN that consumes it.
- Decision priority in IDLE/WALK on SCEN: ko > hit_pend > btn_attack > btn_jump > exactly one of left/right (WALK) > none (IDLE). If left and right are both pressed, result is IDLE.
- JUMP_REQ: `jump`=1, `move_left`/`move_right` hold the direction captured at entry (both 0 if not exactly one pressed). On the next SCEN, go to JUMP_AIR.
- JUMP_AIR: `jump`=0, directions 0, `move_enable`=1. Exit to IDLE on a SCEN sampling `jump_active`=0, or to HITSTUN if `hit_pend`. Buttons are ignored; no air attack. Hits are deferred to landing.
- ATK_START → ATK_ACTIVE → ATK_RECOV → IDLE. `hit_pend` on any SCEN in these states aborts to HITSTUN and deasserts `attack_active` the same edge.
- HITSTUN: a new `hit_pend` reloads the counter (HITSTUN_FRAMES−1). Exit to IDLE.
- `ko`=1 sampled on SCEN in any state sets KO. KO is terminal until reset. In KO, all outputs are 0 except `busy`=1 and `action`=7.
- `move_enable`=1 only in IDLE, WALK, JUMP_REQ, JUMP_AIR. `move_left`/`move_right` follow the buttons in WALK and are 0 in IDLE.
- `attack_active`=1 exactly in ATK_ACTIVE.

## Timing
- Reset values: state IDLE, counter 0, `hit_pend`=0, `ko_latched`=0. All outputs 0, `action`=0.
- All outputs are registered and change only on SCEN edges; latency is one frame from button sample to output.
- `player_move` samples `jump` one SCEN after JUMP_REQ entry. `jump` is high for exactly one frame.
- `hit_taken` coinciding with SCEN is consumed in that same decision.
- Reset mid-attack or mid-air returns to IDLE immediately. The resulting `move_enable`=0 / `jump`=0 does not clear `player_move`'s own jump state; the top level resets both together.

## Structure
- Shared package `fighter_pkg`: state encodings, default frame constants, `CNT_WIDTH`.
- One sub-module, `frame_timer`: loadable down-counter gated by SCEN, with a `done` output at 0.
- The rest is a single FSM with registered outputs: 150–250 lines.

## Test plan
- Hold `btn_right` for 5 frames → WALK from frame 1, `move_right`=1 for 5 frames, `move_enable`=1, IDLE one frame after release.
- Pulse `btn_attack` for 1 frame → ATK_START 3 frames, `attack_active`=1 for exactly 4 frames, ATK_RECOV 6 frames, IDLE at frame 14. `move_enable`=0 throughout.
- `btn_jump`+`btn_left`, with a modeled `player_move` (16-frame jump) → `jump`=1 for one frame with `move_left`=1, JUMP_AIR until `jump_active` falls, then IDLE. `btn_attack` mid-air is ignored.
- `hit_taken` mid-cycle during ATK_ACTIVE frame 2 → next SCEN enters HITSTUN, `attack_active`=0. Second hit at stun frame 10 → 12 further frames, then IDLE.
- `hit_taken` during JUMP_AIR → stays airborne until landing, then HITSTUN for 12 frames.
- `ko`=1 during WALK → KO with all drive outputs 0. Buttons ignored. Asserting `reset`=0 mid-KO → IDLE, all outputs 0.
